// File: rtl/hood_pkg.sv
// Shared definitions for the range-hood mode interface: mode codes and the
// hurricane controller state encoding.
package hood_pkg;

   typedef enum logic [2:0] {
      MODE_STANDBY   = 3'b000,
      MODE_GEAR1     = 3'b001,
      MODE_GEAR2     = 3'b010,
      MODE_HURRICANE = 3'b011,
      MODE_CLEAN     = 3'b100
   } mode_e;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_ARMED,
      ST_RUN,
      ST_RETURN,
      ST_SPENT
   } hc_state_e;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler: counts 0..CLK_PER_SEC-1 while enabled and pulses
// tick on the last count; clr forces the count back to zero.
module sec_tick_gen #(
   parameter int unsigned CLK_PER_SEC = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_PER_SEC - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign tick = en & (cnt_q == LAST);

endmodule

// File: rtl/hurricane_ctrl.sv
// Hurricane (mode 3) permission controller: run countdown, menu-triggered
// return-to-gear-2 countdown, and once-per-power-on lockout.
module hurricane_ctrl
   import hood_pkg::*;
#(
   parameter int unsigned CLK_PER_SEC   = 100_000_000,
   parameter int unsigned HURRICANE_SEC = 60,
   parameter int unsigned RETURN_SEC    = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       machine_state,
   input  logic [2:0] mode_state,
   input  logic       menu_btn,
   output logic       hurricane_mode_enabled,
   output logic       return_state,
   output logic [7:0] countdown_sec,
   output logic       countdown_active
);

   hc_state_e  state_q, state_d;
   logic [7:0] cd_q, cd_d;
   logic       ret_q, ret_d;
   logic       en_q, en_d;
   logic       act_q, act_d;
   logic       menu_prev_q;
   logic       tick, clr, counting, menu_edge, is_hurr;

   assign counting  = (state_q == ST_RUN) || (state_q == ST_RETURN);
   assign menu_edge = menu_btn & ~menu_prev_q;
   assign is_hurr   = (mode_state == MODE_HURRICANE);

   sec_tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (counting),
      .clr  (clr),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      ret_d   = ret_q;
      clr     = ~counting;
      if (!machine_state) begin
         state_d = ST_OFF;
         cd_d    = '0;
         ret_d   = 1'b0;
      end else begin
         case (state_q)
            ST_OFF: state_d = ST_ARMED;
            ST_ARMED: begin
               ret_d = 1'b0;
               if (is_hurr) begin
                  state_d = ST_RUN;
                  cd_d    = 8'(HURRICANE_SEC);
               end
            end
            ST_RUN: begin
               // expiry outranks a same-cycle menu edge
               if (!is_hurr) begin
                  state_d = ST_SPENT;
                  cd_d    = '0;
               end else if (tick && cd_q == 8'd1) begin
                  state_d = ST_SPENT;
                  cd_d    = '0;
                  ret_d   = 1'b0;
               end else if (menu_edge) begin
                  state_d = ST_RETURN;
                  cd_d    = 8'(RETURN_SEC);
                  ret_d   = 1'b1;
                  clr     = 1'b1;
               end else if (tick && cd_q != '0) begin
                  cd_d = cd_q - 8'd1;
               end
            end
            ST_RETURN: begin
               if (!is_hurr || (tick && cd_q == 8'd1)) begin
                  state_d = ST_SPENT;
                  cd_d    = '0;
               end else if (tick && cd_q != '0) begin
                  cd_d = cd_q - 8'd1;
               end
            end
            ST_SPENT: cd_d = '0;
            default: begin
               state_d = ST_OFF;
               cd_d    = '0;
               ret_d   = 1'b0;
            end
         endcase
      end
      en_d  = (state_d == ST_ARMED) || (state_d == ST_RUN) || (state_d == ST_RETURN);
      act_d = (state_d == ST_RUN) || (state_d == ST_RETURN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_OFF;
         cd_q        <= '0;
         ret_q       <= 1'b0;
         en_q        <= 1'b0;
         act_q       <= 1'b0;
         menu_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cd_q        <= cd_d;
         ret_q       <= ret_d;
         en_q        <= en_d;
         act_q       <= act_d;
         menu_prev_q <= menu_btn;
      end
   end

   assign hurricane_mode_enabled = en_q;
   assign return_state           = ret_q;
   assign countdown_sec          = cd_q;
   assign countdown_active       = act_q;

endmodule

// File: tb/tb_hurricane_ctrl.sv
// Scoreboard bench for hurricane_ctrl: expected output words are queued
// against an absolute cycle number and compared on the falling edge.
module tb_hurricane_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       machine_state;
   logic [2:0] mode_state;
   logic       menu_btn;
   logic       hurricane_mode_enabled;
   logic       return_state;
   logic [7:0] countdown_sec;
   logic       countdown_active;

   hurricane_ctrl #(
      .CLK_PER_SEC   (4),
      .HURRICANE_SEC (3),
      .RETURN_SEC    (2)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .machine_state          (machine_state),
      .mode_state             (mode_state),
      .menu_btn               (menu_btn),
      .hurricane_mode_enabled (hurricane_mode_enabled),
      .return_state           (return_state),
      .countdown_sec          (countdown_sec),
      .countdown_active       (countdown_active)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   // observed word layout: {en, ret, act, countdown_sec[7:0]}
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input bit en, input bit ret, input bit act, input int unsigned cd);
      return {21'd0, en, ret, act, cd[7:0]};
   endfunction

   task automatic expect_at(input int unsigned c, input string tag, input logic [31:0] v);
      exp_t e;
      e.cyc = c;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         mon_e = sb.pop_front();
         check_eq(mon_e.tag,
                  {21'd0, hurricane_mode_enabled, return_state, countdown_active, countdown_sec},
                  mon_e.exp);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (sb.size() > 0 && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check_eq({"drain_", tag}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic power_up();
      machine_state = 1'b0;
      mode_state    = 3'b000;
      menu_btn      = 1'b0;
      expect_at(cyc + 1, "off", mk(0, 0, 0, 0));
      step(2);
      machine_state = 1'b1;
      expect_at(cyc + 1, "armed", mk(1, 0, 0, 0));
      step(2);
   endtask

   task automatic enter_run(output int unsigned e);
      mode_state = 3'b011;
      e = cyc + 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned e;
      rst           = 1'b0;
      machine_state = 1'b0;
      mode_state    = 3'b000;
      menu_btn      = 1'b0;
      step(2);
      expect_at(cyc, "reset", mk(0, 0, 0, 0));
      step(1);
      rst = 1'b1;

      // plain expiry, then lockout while mode stays 3
      power_up();
      enter_run(e);
      expect_at(e,      "run_entry",   mk(1, 0, 1, 3));
      expect_at(e + 3,  "run_pre_t1",  mk(1, 0, 1, 3));
      expect_at(e + 4,  "run_t1",      mk(1, 0, 1, 2));
      expect_at(e + 8,  "run_t2",      mk(1, 0, 1, 1));
      expect_at(e + 11, "run_pre_exp", mk(1, 0, 1, 1));
      expect_at(e + 12, "expire",      mk(0, 0, 0, 0));
      expect_at(e + 15, "locked",      mk(0, 0, 0, 0));
      drain("expire");

      // menu edge at cycle 5 -> RETURN, second edge ignored
      power_up();
      enter_run(e);
      expect_at(e + 4,  "pre_menu",    mk(1, 0, 1, 2));
      expect_at(e + 5,  "return",      mk(1, 1, 1, 2));
      expect_at(e + 9,  "ret_t1",      mk(1, 1, 1, 1));
      expect_at(e + 12, "ret_pre_exp", mk(1, 1, 1, 1));
      expect_at(e + 13, "ret_expire",  mk(0, 1, 0, 0));
      step(5);
      menu_btn = 1'b1;
      step(2);
      menu_btn = 1'b0;
      step(2);
      menu_btn = 1'b1;
      drain("return");

      // menu edge on the expiry tick: expiry wins
      power_up();
      enter_run(e);
      expect_at(e + 11, "tie_pre",     mk(1, 0, 1, 1));
      expect_at(e + 12, "expiry_wins", mk(0, 0, 0, 0));
      step(12);
      menu_btn = 1'b1;
      drain("tie");

      // menu held across entry, release and re-press, then async reset
      power_up();
      menu_btn = 1'b1;
      step(1);
      enter_run(e);
      expect_at(e + 5,  "held_no_edge", mk(1, 0, 1, 2));
      expect_at(e + 6,  "held_still",   mk(1, 0, 1, 2));
      expect_at(e + 8,  "repress",      mk(1, 1, 1, 2));
      expect_at(e + 9,  "repress_hold", mk(1, 1, 1, 2));
      step(7);
      menu_btn = 1'b0;
      step(1);
      menu_btn = 1'b1;
      step(3);
      rst = 1'b0;
      expect_at(cyc, "rst_async", mk(0, 0, 0, 0));
      step(1);
      rst = 1'b1;
      expect_at(cyc + 1, "post_rst_armed", mk(1, 0, 0, 0));
      drain("held");

      // power removed mid-RUN
      power_up();
      enter_run(e);
      expect_at(e + 5, "pre_pwr_off", mk(1, 0, 1, 2));
      expect_at(e + 6, "pwr_off",     mk(0, 0, 0, 0));
      step(6);
      machine_state = 1'b0;
      drain("pwr_off");

      // mode leaves hurricane externally
      power_up();
      enter_run(e);
      expect_at(e + 2, "pre_abort", mk(1, 0, 1, 3));
      expect_at(e + 3, "abort",     mk(0, 0, 0, 0));
      step(3);
      mode_state = 3'b000;
      drain("abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
